// File: rtl/pe_stream.sv
// pe_stream: multi-cycle sign-magnitude dot-product processing element.
//
// Accepts LANES input/weight pairs per beat over ceil(N_TERMS/LANES) beats and
// accumulates their products in two's complement. It then adds a scaled bias,
// rescales by SHIFT, optionally applies ReLU and saturates to one
// sign-magnitude word.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a job (honoured only when idle)
//   bias, relu_en     job configuration, latched on the accepted start
//   busy              high whenever a job is in flight
//   in_valid/in_ready beat handshake; in_ready is high only while accumulating
//   in_data/in_weight LANES packed sign-magnitude words, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data  result handshake; out_data holds until next job
module pe_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned N_TERMS    = 62,
  parameter int unsigned LANES      = 2,
  parameter int unsigned ACC_W      = 21,
  parameter int unsigned BIAS_SCALE = 127,
  parameter int unsigned SHIFT      = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W-1:0]         bias,
  input  logic                      relu_en,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*DATA_W-1:0]   in_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data
);

  localparam int unsigned MAG_W  = DATA_W - 1;
  localparam int unsigned PROD_W = 2 * MAG_W;
  // One guard bit so acc +/- bias can never wrap.
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned BEATS  = (N_TERMS + LANES - 1) / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [SUM_W-1:0]  MAG_MAX   = SUM_W'((1 << MAG_W) - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StFinish, StOut} state_e;

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [DATA_W-1:0]        bias_q;
  logic                     relu_q;

  // ---------------------------------------------------------------------------
  // Per-lane signed products
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] lane_term [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] w;
    logic [PROD_W-1:0] p_mag;
    logic [ACC_W-1:0]  p_ext;
    logic              p_neg;
    logic              active;

    assign d      = in_data[g*DATA_W +: DATA_W];
    assign w      = in_weight[g*DATA_W +: DATA_W];
    assign p_mag  = PROD_W'(d[MAG_W-1:0]) * PROD_W'(w[MAG_W-1:0]);
    assign p_neg  = d[DATA_W-1] ^ w[DATA_W-1];
    assign p_ext  = ACC_W'(p_mag);
    // Lanes beyond N_TERMS only occur on the final beat of a ragged split.
    assign active = (32'(beat_q) * LANES + 32'(g)) < N_TERMS;
    // A zero magnitude negates to zero, so negative zero needs no special case.
    assign lane_term[g] = !active ? '0 : (p_neg ? -$signed(p_ext) : $signed(p_ext));
  end

  logic signed [ACC_W-1:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + lane_term[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Bias, rescale, ReLU and saturation (consumed in FINISH)
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]        bias_term;
  logic signed [SUM_W-1:0] total;
  logic                    total_neg;
  logic [SUM_W-1:0]        total_abs;
  logic [SUM_W-1:0]        shifted;
  logic [MAG_W-1:0]        res_mag;
  logic [DATA_W-1:0]       result;

  assign bias_term = ACC_W'(bias_q[MAG_W-1:0]) * ACC_W'(BIAS_SCALE);

  always_comb begin
    if (bias_q[DATA_W-1]) begin
      total = SUM_W'(acc_q) - $signed({1'b0, bias_term});
    end else begin
      total = SUM_W'(acc_q) + $signed({1'b0, bias_term});
    end
    total_neg = total[SUM_W-1];
    // Shift the magnitude so negatives truncate toward zero.
    total_abs = total_neg ? SUM_W'(-total) : SUM_W'(total);
    shifted   = total_abs >> SHIFT;
    res_mag   = (shifted > MAG_MAX) ? '1 : shifted[MAG_W-1:0];
    if (total_neg && relu_q) begin
      result = '0;
    end else begin
      result = {total_neg && (res_mag != '0), res_mag};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      beat_q    <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StAccum;
            acc_q    <= '0;
            beat_q   <= '0;
            bias_q   <= bias;
            relu_q   <= relu_en;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        StAccum: begin
          if (in_valid && in_ready) begin
            acc_q <= acc_q + beat_sum;
            if (beat_q == LAST_BEAT) begin
              state_q  <= StFinish;
              in_ready <= 1'b0;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        StFinish: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream.sv
// Directed bench for pe_stream: a default 2-lane instance and a 4-lane instance.
module tb_pe_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // 2-lane instance (defaults, 31 beats)
  logic        rst_a, start_a, relu_a, in_valid_a, out_ready_a;
  logic [7:0]  bias_a;
  logic [15:0] in_data_a, in_weight_a;
  logic        busy_a, in_ready_a, out_valid_a;
  logic [7:0]  out_data_a;

  pe_stream dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .start     (start_a),
    .bias      (bias_a),
    .relu_en   (relu_a),
    .busy      (busy_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .in_weight (in_weight_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a)
  );

  // 4-lane instance (16 beats, last beat lanes 2-3 masked)
  logic        rst_b, start_b, relu_b, in_valid_b, out_ready_b;
  logic [7:0]  bias_b;
  logic [31:0] in_data_b, in_weight_b;
  logic        busy_b, in_ready_b, out_valid_b;
  logic [7:0]  out_data_b;

  pe_stream #(.LANES(4)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .start     (start_b),
    .bias      (bias_b),
    .relu_en   (relu_b),
    .busy      (busy_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .in_weight (in_weight_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b)
  );

  // Runs one job on dut_a. Entered and left 1ns after a rising edge.
  // lat: edges from the last-beat edge until out_valid is seen.
  // total: edges from the start-accept edge until out_valid is seen.
  task automatic job_a(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b,
                       input logic r, input bit stall, input int hold_n, input bit poke,
                       output logic [7:0] res, output int lat, output int total,
                       output int ready_hi, output int unstable, output bit ready_first,
                       output bit timeout);
    int beats;
    int guard;
    int s0, s1, s2;
    logic [2:0] done_st;
    logic acc;
    timeout  = 1'b0;
    ready_hi = 0;
    unstable = 0;
    s0 = $urandom_range(9, 0);
    s1 = $urandom_range(19, 10);
    s2 = $urandom_range(30, 20);
    done_st = '0;
    start_a = 1'b1;
    bias_a  = b;
    relu_a  = r;
    @(posedge clk); #1;
    start_a = 1'b0;
    // Scramble config after acceptance; the running job must ignore it.
    bias_a  = ~b;
    relu_a  = ~r;
    ready_first = in_ready_a;
    beats = 0;
    guard = 0;
    while (beats < 31 && guard < 200) begin
      in_valid_a  = 1'b1;
      in_data_a   = {d, d};
      in_weight_a = {w, w};
      if (stall) begin
        if (beats == s0 && !done_st[0]) begin
          in_valid_a = 1'b0; done_st[0] = 1'b1;
        end else if (beats == s1 && !done_st[1]) begin
          in_valid_a = 1'b0; done_st[1] = 1'b1;
        end else if (beats == s2 && !done_st[2]) begin
          in_valid_a = 1'b0; done_st[2] = 1'b1;
        end
        if (!in_valid_a) begin
          in_data_a   = 16'($urandom);
          in_weight_a = 16'($urandom);
        end
      end
      start_a = poke && (beats == 7);
      acc = in_valid_a && in_ready_a;
      @(posedge clk); #1;
      if (acc) beats++;
      guard++;
    end
    in_valid_a = 1'b0;
    start_a    = 1'b0;
    if (beats != 31) timeout = 1'b1;
    lat = 0;
    while (!out_valid_a && lat < 10) begin
      if (in_ready_a) ready_hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid_a) timeout = 1'b1;
    total = guard + lat;
    res = out_data_a;
    for (int i = 0; i < hold_n; i++) begin
      out_ready_a = 1'b0;
      start_a = poke;
      if (in_ready_a) ready_hi++;
      @(posedge clk); #1;
      if (!out_valid_a || out_data_a !== res) unstable++;
    end
    // A start on the handshake edge itself must not be taken.
    start_a     = poke;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    start_a     = 1'b0;
  endtask

  // Runs one job on dut_b; abort_at >= 0 stops after that many accepted beats
  // and leaves the job in flight.
  task automatic job_b(input int abort_at, output logic [7:0] res, output int lat,
                       output bit timeout);
    int beats;
    int guard;
    logic acc;
    timeout = 1'b0;
    res     = '0;
    lat     = 0;
    start_b = 1'b1;
    bias_b  = 8'h00;
    relu_b  = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 16 && guard < 100 && !(abort_at >= 0 && beats == abort_at)) begin
      in_valid_b  = 1'b1;
      in_data_b   = (beats == 15) ? {8'h7F, 8'h7F, 8'h01, 8'h01} : {4{8'h01}};
      in_weight_b = {4{8'h7F}};
      acc = in_valid_b && in_ready_b;
      @(posedge clk); #1;
      if (acc) beats++;
      guard++;
    end
    in_valid_b = 1'b0;
    if (abort_at < 0) begin
      if (beats != 16) timeout = 1'b1;
      while (!out_valid_b && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      if (!out_valid_b) timeout = 1'b1;
      res = out_data_b;
      out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready_b = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec += 4;
    if (busy_a !== 1'b0)      begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (in_ready_a !== 1'b0)  begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a); end
    if (out_valid_a !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    if (out_data_a !== 8'h00) begin nerr++; $display("FAIL reset_out_data: got %h want 00", out_data_a); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    nvec += 2;
    if (busy_a !== 1'b0)     begin nerr++; $display("FAIL idle_busy: got %b want 0", busy_a); end
    if (in_ready_a !== 1'b0) begin nerr++; $display("FAIL idle_in_ready: got %b want 0", in_ready_a); end
  endtask

  task automatic test_basic;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    // 62 * 127 = 7874; 7874 >> 9 = 15
    job_a(8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 8;
    if (to !== 1'b0)     begin nerr++; $display("FAIL basic_timeout: got %b want 0", to); end
    if (res !== 8'h0F)   begin nerr++; $display("FAIL basic_result: got %h want 0f", res); end
    if (rf !== 1'b1)     begin nerr++; $display("FAIL basic_ready_after_start: got %b want 1", rf); end
    if (lat != 1)        begin nerr++; $display("FAIL basic_finish_latency: got %0d want 1", lat); end
    if (total != 32)     begin nerr++; $display("FAIL basic_start_to_valid: got %0d want 32", total); end
    if (busy_a !== 1'b0) begin nerr++; $display("FAIL basic_busy_after_hs: got %b want 0", busy_a); end
    if (out_valid_a !== 1'b0) begin nerr++; $display("FAIL basic_valid_after_hs: got %b want 0", out_valid_a); end
    if (out_data_a !== 8'h0F) begin nerr++; $display("FAIL basic_hold_after_hs: got %h want 0f", out_data_a); end
  endtask

  task automatic test_saturate;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    // 62*16129 + 16129 = 1016127; >> 9 = 1984 -> clamps to 127
    job_a(8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'h7F) begin nerr++; $display("FAIL saturate: got %h want 7f", res); end
  endtask

  task automatic test_negative;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    // 62 * (-5*127) = -39370
    job_a(8'h85, 8'h7F, 8'h00, 1'b1, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'h00) begin nerr++; $display("FAIL negative_relu: got %h want 00", res); end
    // 39370 >> 9 = 76 = 0x4c, negative
    job_a(8'h85, 8'h7F, 8'h00, 1'b0, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'hCC) begin nerr++; $display("FAIL negative_signed: got %h want cc", res); end
  endtask

  task automatic test_bias;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    // 62 - 16129 = -16067; 16067 >> 9 = 31
    job_a(8'h01, 8'h01, 8'hFF, 1'b0, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'h9F) begin nerr++; $display("FAIL bias_neg: got %h want 9f", res); end
    // 62 - 127 = -65; 65 >> 9 = 0 -> positive zero
    job_a(8'h01, 8'h01, 8'h81, 1'b0, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'h00) begin nerr++; $display("FAIL bias_no_neg_zero: got %h want 00", res); end
  endtask

  task automatic test_stall;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    job_a(8'h01, 8'h7F, 8'h00, 1'b1, 1'b1, 5, 1'b1, res, lat, total, rh, un, rf, to);
    nvec += 7;
    if (to !== 1'b0)   begin nerr++; $display("FAIL stall_timeout: got %b want 0", to); end
    if (res !== 8'h0F) begin nerr++; $display("FAIL stall_result: got %h want 0f", res); end
    if (lat != 1)      begin nerr++; $display("FAIL stall_finish_latency: got %0d want 1", lat); end
    if (total != 35)   begin nerr++; $display("FAIL stall_start_to_valid: got %0d want 35", total); end
    if (un != 0)       begin nerr++; $display("FAIL stall_out_stable: got %0d unstable cycles want 0", un); end
    if (rh != 0)       begin nerr++; $display("FAIL stall_in_ready_outside: got %0d cycles want 0", rh); end
    if (busy_a !== 1'b0) begin nerr++; $display("FAIL stall_start_on_hs: busy got %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] res; int lat, total, rh, un; bit rf, to;
    // Start in the cycle right after a handshake.
    job_a(8'h01, 8'h01, 8'hFF, 1'b0, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    job_a(8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 0, 1'b0, res, lat, total, rh, un, rf, to);
    nvec += 1;
    if (to || res !== 8'h0F) begin nerr++; $display("FAIL back_to_back: got %h want 0f", res); end
  endtask

  task automatic test_lanes4;
    logic [7:0] res; int lat; bit to;
    job_b(-1, res, lat, to);
    nvec += 2;
    if (to || res !== 8'h0F) begin nerr++; $display("FAIL lanes4_result: got %h want 0f", res); end
    if (lat != 1)            begin nerr++; $display("FAIL lanes4_latency: got %0d want 1", lat); end
  endtask

  task automatic test_reset_midjob;
    logic [7:0] res; int lat; bit to;
    job_b(10, res, lat, to);
    nvec += 1;
    if (busy_b !== 1'b1) begin nerr++; $display("FAIL midjob_busy_before_rst: got %b want 1", busy_b); end
    #2;
    rst_b = 1'b1;
    #1;
    nvec += 4;
    if (busy_b !== 1'b0)      begin nerr++; $display("FAIL midjob_rst_busy: got %b want 0", busy_b); end
    if (in_ready_b !== 1'b0)  begin nerr++; $display("FAIL midjob_rst_in_ready: got %b want 0", in_ready_b); end
    if (out_valid_b !== 1'b0) begin nerr++; $display("FAIL midjob_rst_out_valid: got %b want 0", out_valid_b); end
    if (out_data_b !== 8'h00) begin nerr++; $display("FAIL midjob_rst_out_data: got %h want 00", out_data_b); end
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    job_b(-1, res, lat, to);
    nvec += 1;
    if (to || res !== 8'h0F) begin nerr++; $display("FAIL midjob_rerun: got %h want 0f", res); end
  endtask

  initial begin
    start_a = 1'b0; relu_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    bias_a = '0; in_data_a = '0; in_weight_a = '0;
    start_b = 1'b0; relu_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    bias_b = '0; in_data_b = '0; in_weight_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    test_reset;
    test_basic;
    test_saturate;
    test_negative;
    test_bias;
    test_stall;
    test_back_to_back;
    test_lanes4;
    test_reset_midjob;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
